morse_rx_decoder: RTL and testbench

Receive-side counterpart of the Morse symbol transmitter FSM. It consumes the 3-bit per-cycle symbol stream that the transmitter emits (dot, dash, 3-cycle character gap, 7-cycle word gap) and rebuilds ASCII characters. It checks gap run lengths and delivers characters through a valid/ready FIFO to the downstream sink (UART/display path).

---
 rtl/morse_pkg.sv | 39 +++
 rtl/morse_lut.sv | 66 ++++++
 rtl/morse_rx_decoder.sv | 203 ++++++++++++++++++++
 tb/tb_morse_rx_decoder.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// morse_pkg: shared definitions for the Morse symbol transmitter / receiver pair.
//   - 3-bit per-cycle symbol codes on the link between the two
//   - ASCII codes used for the inserted space and for unrecognised patterns
//   - element buffer geometry and the run-length counter type
package morse_pkg;

    // Symbol codes carried on the per-cycle link (101..111 are illegal)
    localparam logic [2:0] SYM_IDLE = 3'b000;
    localparam logic [2:0] SYM_DOT  = 3'b001;
    localparam logic [2:0] SYM_DASH = 3'b010;
    localparam logic [2:0] SYM_CGAP = 3'b011;
    localparam logic [2:0] SYM_WGAP = 3'b100;

    localparam logic [7:0] ASCII_SPACE   = 8'h20;
    localparam logic [7:0] ASCII_UNKNOWN = 8'h3F;

    // Longest character (digits) has 5 elements; one spare before discarding
    localparam int unsigned MAX_ELEMS = 6;
    localparam int unsigned LEN_W     = 3;

    // Run counter saturates at 8, enough to tell a 7-cycle word gap from a longer one
    localparam int unsigned RUN_W = 4;

    typedef logic [2:0]           sym_t;
    typedef logic [LEN_W-1:0]     elem_len_t;
    typedef logic [MAX_ELEMS-1:0] elem_pat_t;
    typedef logic [RUN_W-1:0]     run_cnt_t;

    localparam run_cnt_t RUN_SAT = 4'd8;

    function automatic logic is_element(sym_t s);
        return (s == SYM_DOT) || (s == SYM_DASH);
    endfunction

    function automatic logic is_illegal(sym_t s);
        return s > SYM_WGAP;
    endfunction

endpackage

// File: rtl/morse_lut.sv
// morse_lut: combinational Morse pattern to ASCII decoder.
//   len   in  3  number of valid elements (0..6)
//   pat   in  6  element k at pat[k], dash = 1, dot = 0
//   ascii out 8  uppercase letter or digit; '?' for any unassigned pattern
module morse_lut
    import morse_pkg::*;
(
    input  logic [LEN_W-1:0]     len,
    input  logic [MAX_ELEMS-1:0] pat,
    output logic [7:0]           ascii
);

    logic [MAX_ELEMS-1:0] pat_mask;
    logic [MAX_ELEMS-1:0] pat_m;

    // Bits at or above len are not elements; mask them so stale bits cannot alias.
    // For len == 6 the shift wraps to zero and the subtraction yields all ones.
    assign pat_mask = (elem_pat_t'(1) << len) - elem_pat_t'(1);
    assign pat_m    = pat & pat_mask;

    // Patterns are written with the first element in the LSB, i.e. reversed
    // relative to the usual left-to-right Morse notation.
    always_comb begin
        ascii = ASCII_UNKNOWN;
        case ({len, pat_m})
            {3'd2, 6'b000010}: ascii = 8'h41; // A .-
            {3'd4, 6'b000001}: ascii = 8'h42; // B -...
            {3'd4, 6'b000101}: ascii = 8'h43; // C -.-.
            {3'd3, 6'b000001}: ascii = 8'h44; // D -..
            {3'd1, 6'b000000}: ascii = 8'h45; // E .
            {3'd4, 6'b000100}: ascii = 8'h46; // F ..-.
            {3'd3, 6'b000011}: ascii = 8'h47; // G --.
            {3'd4, 6'b000000}: ascii = 8'h48; // H ....
            {3'd2, 6'b000000}: ascii = 8'h49; // I ..
            {3'd4, 6'b001110}: ascii = 8'h4A; // J .---
            {3'd3, 6'b000101}: ascii = 8'h4B; // K -.-
            {3'd4, 6'b000010}: ascii = 8'h4C; // L .-..
            {3'd2, 6'b000011}: ascii = 8'h4D; // M --
            {3'd2, 6'b000001}: ascii = 8'h4E; // N -.
            {3'd3, 6'b000111}: ascii = 8'h4F; // O ---
            {3'd4, 6'b000110}: ascii = 8'h50; // P .--.
            {3'd4, 6'b001011}: ascii = 8'h51; // Q --.-
            {3'd3, 6'b000010}: ascii = 8'h52; // R .-.
            {3'd3, 6'b000000}: ascii = 8'h53; // S ...
            {3'd1, 6'b000001}: ascii = 8'h54; // T -
            {3'd3, 6'b000100}: ascii = 8'h55; // U ..-
            {3'd4, 6'b001000}: ascii = 8'h56; // V ...-
            {3'd3, 6'b000110}: ascii = 8'h57; // W .--
            {3'd4, 6'b001001}: ascii = 8'h58; // X -..-
            {3'd4, 6'b001101}: ascii = 8'h59; // Y -.--
            {3'd4, 6'b000011}: ascii = 8'h5A; // Z --..
            {3'd5, 6'b011111}: ascii = 8'h30; // 0 -----
            {3'd5, 6'b011110}: ascii = 8'h31; // 1 .----
            {3'd5, 6'b011100}: ascii = 8'h32; // 2 ..---
            {3'd5, 6'b011000}: ascii = 8'h33; // 3 ...--
            {3'd5, 6'b010000}: ascii = 8'h34; // 4 ....-
            {3'd5, 6'b000000}: ascii = 8'h35; // 5 .....
            {3'd5, 6'b000001}: ascii = 8'h36; // 6 -....
            {3'd5, 6'b000011}: ascii = 8'h37; // 7 --...
            {3'd5, 6'b000111}: ascii = 8'h38; // 8 ---..
            {3'd5, 6'b001111}: ascii = 8'h39; // 9 ----.
            default:           ascii = ASCII_UNKNOWN;
        endcase
    end

endmodule

// File: rtl/morse_rx_decoder.sv
// morse_rx_decoder: rebuilds ASCII characters from the per-cycle Morse symbol stream.
//   clk        in   1  clock
//   rst        in   1  asynchronous active-low reset
//   sym_in     in   3  symbol code sampled every rising edge
//   char_data  out  8  character at the FIFO head (0 when empty)
//   char_valid out  1  FIFO non-empty
//   char_ready in   1  sink accepts; pop when char_valid && char_ready
//   frame_err  out  1  one-cycle pulse after a protocol violation
//   overflow   out  1  sticky: a character was dropped on a full FIFO
module morse_rx_decoder
    import morse_pkg::*;
#(
    parameter int unsigned CHAR_GAP_LEN = 3,
    parameter int unsigned WORD_GAP_LEN = 7,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] sym_in,
    output logic [7:0] char_data,
    output logic       char_valid,
    input  logic       char_ready,
    output logic       frame_err,
    output logic       overflow
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [0:0] ST_COLLECT    = 1'b0;
    localparam logic [0:0] ST_EMIT_SPACE = 1'b1;

    localparam run_cnt_t        CGAP_CNT  = run_cnt_t'(CHAR_GAP_LEN);
    localparam run_cnt_t        WGAP_CNT  = run_cnt_t'(WORD_GAP_LEN);
    localparam elem_len_t       FULL_LEN  = elem_len_t'(MAX_ELEMS);
    localparam logic [PTR_W:0]  DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    // Element buffer and run tracker
    elem_len_t  len_q, len_d;
    elem_pat_t  pat_q, pat_d;
    logic       discard_q, discard_d;
    sym_t       run_code_q, run_code_d;
    run_cnt_t   run_cnt_q, run_cnt_d;
    logic [0:0] state_q, state_d;
    logic       frame_err_q, frame_err_d;
    logic       overflow_q, overflow_d;

    // Character push request towards the FIFO
    logic       push;
    logic [7:0] push_data;
    logic [7:0] lut_char;
    logic       gap_end;

    // FIFO
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q, count_d;
    logic             fifo_full;
    logic             pop;
    logic             push_ok;

    morse_lut u_lut (
        .len   (len_q),
        .pat   (pat_q),
        .ascii (lut_char)
    );

    // A gap run is judged on the first edge whose sample breaks it
    assign gap_end = (sym_in != run_code_q) &&
                     ((run_code_q == SYM_CGAP) || (run_code_q == SYM_WGAP));

    always_comb begin
        len_d       = len_q;
        pat_d       = pat_q;
        discard_d   = discard_q;
        run_code_d  = run_code_q;
        run_cnt_d   = run_cnt_q;
        state_d     = ST_COLLECT;
        frame_err_d = 1'b0;
        push        = 1'b0;
        push_data   = lut_char;

        // Gap evaluation works on the buffer as it stood before this edge
        if (gap_end) begin
            if (discard_q) begin
                frame_err_d = 1'b1;
            end else if (run_code_q == SYM_CGAP) begin
                if (run_cnt_q == CGAP_CNT) begin
                    push = (len_q != '0);
                end else begin
                    frame_err_d = 1'b1;
                end
            end else begin
                if (run_cnt_q == WGAP_CNT) begin
                    push = 1'b1;
                    if (len_q != '0) begin
                        state_d = ST_EMIT_SPACE;
                    end else begin
                        push_data = ASCII_SPACE;
                    end
                end else begin
                    frame_err_d = 1'b1;
                end
            end
            len_d     = '0;
            pat_d     = '0;
            discard_d = 1'b0;
        end

        // Deferred space of a word gap that closed a pending character
        if (state_q == ST_EMIT_SPACE) begin
            push      = 1'b1;
            push_data = ASCII_SPACE;
        end

        // Element capture lands in the buffer left after any gap clear above,
        // so an element that directly ends a gap starts the next character.
        if (is_element(sym_in) && !discard_d) begin
            if (len_d == FULL_LEN) begin
                discard_d = 1'b1;
            end else begin
                pat_d = pat_d | (elem_pat_t'(sym_in == SYM_DASH) << len_d);
                len_d = len_d + 1'b1;
            end
        end

        if (is_illegal(sym_in)) begin
            frame_err_d = 1'b1;
            len_d       = '0;
            pat_d       = '0;
            discard_d   = 1'b0;
        end

        if (sym_in == run_code_q) begin
            if (run_cnt_q != RUN_SAT) begin
                run_cnt_d = run_cnt_q + 1'b1;
            end
        end else begin
            run_code_d = sym_in;
            run_cnt_d  = run_cnt_t'(1);
        end
    end

    // FIFO control: a push into a full FIFO is still taken when a pop frees a slot
    assign fifo_full  = (count_q == DEPTH_CNT);
    assign char_valid = (count_q != '0);
    assign pop        = char_valid && char_ready;
    assign push_ok    = push && (!fifo_full || pop);
    assign overflow_d = overflow_q || (push && fifo_full && !pop);

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    assign char_data = char_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q       <= '0;
            pat_q       <= '0;
            discard_q   <= 1'b0;
            run_code_q  <= SYM_IDLE;
            run_cnt_q   <= '0;
            state_q     <= ST_COLLECT;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            len_q       <= len_d;
            pat_q       <= pat_d;
            discard_q   <= discard_d;
            run_code_q  <= run_code_d;
            run_cnt_q   <= run_cnt_d;
            state_q     <= state_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
            count_q     <= count_d;
            // Pointers wrap naturally since the depth is a power of two
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Storage needs no reset: char_data is gated by char_valid
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: tb/tb_morse_rx_decoder.sv
// tb_morse_rx_decoder: directed plus randomized checks of morse_rx_decoder against a
// string-level reference model (Morse text table, element strings, queue-based FIFO).
module tb_morse_rx_decoder;
    import morse_pkg::*;

    localparam int CGAP  = 3;
    localparam int WGAP  = 7;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic [2:0] sym_in;
    logic [7:0] char_data;
    logic       char_valid;
    logic       char_ready;
    logic       frame_err;
    logic       overflow;

    morse_rx_decoder #(
        .CHAR_GAP_LEN (CGAP),
        .WORD_GAP_LEN (WGAP),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sym_in     (sym_in),
        .char_data  (char_data),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int ready_pct = 100;

    string tab_chars = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";
    string morse_tab [36] = '{
        ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
        "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
        "..-", "...-", ".--", "-..-", "-.--", "--..",
        "-----", ".----", "..---", "...--", "....-",
        ".....", "-....", "--...", "---..", "----."
    };

    // Reference model state
    string      m_elems;
    bit         m_discard;
    logic [2:0] m_run_sym;
    int         m_run_len;
    bit         m_space_pend;
    logic [7:0] m_fifo [$];
    bit         m_ovf;
    bit         m_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] lookup(input string e);
        foreach (morse_tab[i]) begin
            if (morse_tab[i] == e) return tab_chars[i];
        end
        return 8'h3F;
    endfunction

    function automatic bit rr();
        return $urandom_range(0, 99) < ready_pct;
    endfunction

    task automatic model_reset();
        m_elems      = "";
        m_discard    = 0;
        m_run_sym    = 3'd0;
        m_run_len    = 0;
        m_space_pend = 0;
        m_fifo.delete();
        m_ovf        = 0;
        m_err        = 0;
    endtask

    // One clock edge of the reference: gaps close on the first differing sample
    task automatic model_step(input logic [2:0] s, input bit r);
        logic [7:0] pushes [$];
        bit pend;
        bit pop;
        int need;
        pop          = (m_fifo.size() > 0) && r;
        m_err        = 0;
        pend         = m_space_pend;
        m_space_pend = 0;
        if (s != m_run_sym && (m_run_sym == 3'd3 || m_run_sym == 3'd4)) begin
            need = (m_run_sym == 3'd3) ? CGAP : WGAP;
            if (m_discard || m_run_len != need) begin
                m_err = 1;
            end else if (m_elems.len() > 0) begin
                pushes.push_back(lookup(m_elems));
                if (m_run_sym == 3'd4) m_space_pend = 1;
            end else if (m_run_sym == 3'd4) begin
                pushes.push_back(8'h20);
            end
            m_elems   = "";
            m_discard = 0;
        end
        if (pend) pushes.push_back(8'h20);
        if ((s == 3'd1 || s == 3'd2) && !m_discard) begin
            if (m_elems.len() == 6) m_discard = 1;
            else if (s == 3'd2) m_elems = {m_elems, "-"};
            else m_elems = {m_elems, "."};
        end
        if (s >= 3'd5) begin
            m_err     = 1;
            m_elems   = "";
            m_discard = 0;
        end
        if (s == m_run_sym) m_run_len++;
        else begin
            m_run_sym = s;
            m_run_len = 1;
        end
        if (pop) void'(m_fifo.pop_front());
        foreach (pushes[i]) begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back(pushes[i]);
            else m_ovf = 1;
        end
    endtask

    task automatic compare_outputs();
        check_eq("char_valid", char_valid, m_fifo.size() > 0);
        check_eq("char_data", char_data, (m_fifo.size() > 0) ? m_fifo[0] : 8'h00);
        check_eq("frame_err", frame_err, m_err);
        check_eq("overflow", overflow, m_ovf);
    endtask

    task automatic tick(input logic [2:0] s, input bit r);
        sym_in     = s;
        char_ready = r;
        @(posedge clk);
        model_step(s, r);
        #1;
        compare_outputs();
    endtask

    task automatic ticks(input logic [2:0] s, input int n, input bit r);
        for (int i = 0; i < n; i++) tick(s, r);
    endtask

    task automatic send_code(input string code, input bit r, input bit gaps);
        for (int i = 0; i < code.len(); i++) begin
            tick((code[i] == "-") ? SYM_DASH : SYM_DOT, r);
            if (!gaps || $urandom_range(0, 3) != 0) tick(SYM_IDLE, r);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        model_reset();
        check_eq("rst_valid", char_valid, 0);
        check_eq("rst_data", char_data, 0);
        check_eq("rst_frame_err", frame_err, 0);
        check_eq("rst_overflow", overflow, 0);
        #2;
        rst = 1'b1;
    endtask

    initial begin
        logic [7:0] exp_drain [4];
        string rs;
        int k;
        int g;
        exp_drain  = '{8'h41, 8'h42, 8'h43, 8'h44};
        rst        = 1'b0;
        sym_in     = SYM_IDLE;
        char_ready = 1'b0;
        model_reset();
        #12;
        check_eq("rst_valid", char_valid, 0);
        check_eq("rst_data", char_data, 0);
        check_eq("rst_overflow", overflow, 0);
        rst = 1'b1;

        // Letter A, char_valid for exactly one cycle
        send_code(".-", 1, 0);
        ticks(SYM_CGAP, 3, 1);
        tick(SYM_IDLE, 1);
        check_eq("A_valid", char_valid, 1);
        check_eq("A_data", char_data, 8'h41);
        tick(SYM_IDLE, 1);
        check_eq("A_gone", char_valid, 0);

        // E then word gap: E and space on consecutive cycles
        send_code(".", 1, 0);
        ticks(SYM_WGAP, 7, 1);
        tick(SYM_IDLE, 1);
        check_eq("E_data", char_data, 8'h45);
        tick(SYM_IDLE, 1);
        check_eq("space_valid", char_valid, 1);
        check_eq("space_data", char_data, 8'h20);
        tick(SYM_IDLE, 1);

        // Short char gap, then buffer must be empty
        tick(SYM_DASH, 1);
        tick(SYM_IDLE, 1);
        ticks(SYM_CGAP, 2, 1);
        tick(SYM_IDLE, 1);
        check_eq("short_gap_err", frame_err, 1);
        check_eq("short_gap_nopush", char_valid, 0);
        send_code(".", 1, 0);
        ticks(SYM_CGAP, 3, 1);
        tick(SYM_IDLE, 1);
        check_eq("after_err_E", char_data, 8'h45);
        tick(SYM_IDLE, 1);

        // Backpressure: five letters into a 4-deep FIFO
        send_code(".-", 0, 0);   ticks(SYM_CGAP, 3, 0);
        send_code("-...", 0, 0); ticks(SYM_CGAP, 3, 0);
        send_code("-.-.", 0, 0); ticks(SYM_CGAP, 3, 0);
        send_code("-..", 0, 0);  ticks(SYM_CGAP, 3, 0);
        send_code(".", 0, 0);    ticks(SYM_CGAP, 3, 0);
        tick(SYM_IDLE, 0);
        check_eq("bp_overflow", overflow, 1);
        for (int i = 0; i < 4; i++) begin
            check_eq("bp_drain", char_data, exp_drain[i]);
            tick(SYM_IDLE, 1);
        end
        check_eq("bp_empty", char_valid, 0);
        check_eq("bp_sticky", overflow, 1);

        // Illegal symbol
        tick(3'b101, 1);
        check_eq("illegal_err", frame_err, 1);
        tick(SYM_IDLE, 1);
        check_eq("err_pulse_len", frame_err, 0);

        // Seven elements: discarded with an error at the gap
        ticks(SYM_DOT, 7, 1);
        ticks(SYM_CGAP, 3, 1);
        tick(SYM_IDLE, 1);
        check_eq("seven_err", frame_err, 1);
        check_eq("seven_nochar", char_valid, 0);

        // Reset mid-gap with a character held in the FIFO
        send_code(".", 0, 0);
        ticks(SYM_CGAP, 3, 0);
        send_code(".-", 0, 0);
        ticks(SYM_CGAP, 2, 0);
        do_reset();
        send_code(".", 1, 0);
        ticks(SYM_CGAP, 3, 1);
        tick(SYM_IDLE, 1);
        check_eq("post_rst_E", char_data, 8'h45);

        // Randomized traffic
        for (int it = 0; it < 300; it++) begin
            if (it % 40 == 0) begin
                k = $urandom_range(0, 3);
                ready_pct = (k == 0) ? 100 : (k == 1) ? 70 : (k == 2) ? 30 : 0;
            end
            k = $urandom_range(0, 99);
            if (k < 65) begin
                send_code(morse_tab[$urandom_range(0, 35)], rr(), 1);
            end else if (k < 78) begin
                rs = "";
                for (int j = 0; j < $urandom_range(1, 8); j++) begin
                    if ($urandom_range(0, 1) != 0) rs = {rs, "-"};
                    else rs = {rs, "."};
                end
                send_code(rs, rr(), 1);
            end else if (k < 83) begin
                tick(3'($urandom_range(5, 7)), rr());
            end else begin
                ticks(SYM_IDLE, $urandom_range(1, 4), rr());
            end
            g = $urandom_range(0, 9);
            if (g < 6) for (int j = 0; j < CGAP; j++) tick(SYM_CGAP, rr());
            else if (g < 8) for (int j = 0; j < WGAP; j++) tick(SYM_WGAP, rr());
            else if (g == 8) for (int j = 0; j < $urandom_range(1, 9); j++) tick(SYM_CGAP, rr());
            else for (int j = 0; j < $urandom_range(1, 10); j++) tick(SYM_WGAP, rr());
            if ($urandom_range(0, 1) != 0) tick(SYM_IDLE, rr());
        end
        ticks(SYM_IDLE, 8, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
